// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared definitions for the multi-cycle MIPS control path:
//               state codes, opcodes, ALU operation codes, ALU source-B and
//               PC-source mux encodings, and the packed control word that
//               the output decoder hands to the controller top level.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // ------------------------------------------------------------------
    // Controller states (4-bit code, also exported on state_o)
    // ------------------------------------------------------------------
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_EXEC_I   = 4'd9;
    localparam logic [3:0] S_I_WB     = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    // ------------------------------------------------------------------
    // Opcodes (IR[31:26])
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // ------------------------------------------------------------------
    // ALU operation codes (shared with ALU control)
    // ------------------------------------------------------------------
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011;

    // ------------------------------------------------------------------
    // ALU source-B select
    // ------------------------------------------------------------------
    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // ------------------------------------------------------------------
    // PC source select
    // ------------------------------------------------------------------
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Full set of datapath controls produced each cycle
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       retire;
        logic       illegal;
    } ctrl_word_t;

    // True for every opcode the controller knows how to sequence
    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
            OP_ADDI, OP_SLTI, OP_LW, OP_SW: is_legal_op = 1'b1;
            default:                        is_legal_op = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_outdec.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_outdec
// Description : Purely combinational decode of the controller state into
//               the datapath control word. Only the handshake states look
//               at the memory ready input; opcode refines DECODE, BRANCH
//               and EXEC_I. Reset forces all enables low and leaves the
//               selects at their FETCH values.
// Ports       : i_state     - registered controller state
//               i_opcode    - IR[31:26]
//               i_mem_ready - memory completes this cycle
//               i_rst       - reset gating
//               o_ctrl      - decoded control word
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    input  logic       i_rst,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_req   = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                // IR and PC+4 are captured on the same edge the read lands
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.illegal   = ~is_legal_op(i_opcode);
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.retire     = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.mem_we  = 1'b1;
                o_ctrl.i_or_d  = 1'b1;
                // A store has nothing left to do once memory accepts it
                o_ctrl.retire  = i_mem_ready;
            end
            S_EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_RT;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_RT;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.branch_ne     = (i_opcode == OP_BNE);
                o_ctrl.retire        = 1'b1;
            end
            S_EXEC_I: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = (i_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_I_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.retire    = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
                o_ctrl.retire    = 1'b1;
            end
            default: o_ctrl = '0;
        endcase

        // Reset: nothing may write, selects park at their FETCH values
        if (i_rst) begin
            o_ctrl           = '0;
            o_ctrl.alu_src_b = SRCB_FOUR;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Moore control FSM for a shared multi-cycle MIPS datapath.
//               Holds the state register, next-state logic and the
//               retired-instruction counter; control outputs come from
//               multicycle_ctrl_outdec.
// Ports       : clk_i / rst_i      - clock, synchronous active-high reset
//               opcode_i           - IR[31:26]
//               mem_ready_i        - memory handshake
//               mem_*/i_or_d_o     - memory port controls
//               ir_write_o, pc_*   - IR / PC load controls
//               alu_*              - ALU operand selects and operation
//               reg_*, mem_to_reg_o- register-file write controls
//               state_o            - current state
//               retire_o/illegal_o - completion / bad-opcode pulses
//               instr_cnt_o        - retired-instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             i_or_d_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic             branch_ne_o,
    output logic [1:0]       pc_source_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic [3:0]       state_o,
    output logic             retire_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [CNT_W-1:0] r_instr_cnt;
    ctrl_word_t       w_ctrl;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:    w_next_state = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW:     w_next_state = S_MEM_ADDR;
                    OP_RTYPE:         w_next_state = S_EXEC_R;
                    OP_BEQ, OP_BNE:   w_next_state = S_BRANCH;
                    OP_ADDI, OP_SLTI: w_next_state = S_EXEC_I;
                    OP_J:             w_next_state = S_JUMP;
                    default:          w_next_state = S_FETCH;
                endcase
            end
            // Only LW and SW reach address generation
            S_MEM_ADDR: w_next_state = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next_state = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next_state = mem_ready_i ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   w_next_state = S_R_WB;
            S_EXEC_I:   w_next_state = S_I_WB;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Output decode
    multicycle_ctrl_outdec u_outdec (
        .i_state     (r_state),
        .i_opcode    (opcode_i),
        .i_mem_ready (mem_ready_i),
        .i_rst       (rst_i),
        .o_ctrl      (w_ctrl)
    );

    // Retired-instruction counter; retire is already low during reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_instr_cnt <= '0;
        end else if (w_ctrl.retire) begin
            r_instr_cnt <= r_instr_cnt + c_cnt_one;
        end
    end

    assign mem_req_o       = w_ctrl.mem_req;
    assign mem_we_o        = w_ctrl.mem_we;
    assign i_or_d_o        = w_ctrl.i_or_d;
    assign ir_write_o      = w_ctrl.ir_write;
    assign pc_write_o      = w_ctrl.pc_write;
    assign pc_write_cond_o = w_ctrl.pc_write_cond;
    assign branch_ne_o     = w_ctrl.branch_ne;
    assign pc_source_o     = w_ctrl.pc_source;
    assign alu_src_a_o     = w_ctrl.alu_src_a;
    assign alu_src_b_o     = w_ctrl.alu_src_b;
    assign alu_op_o        = w_ctrl.alu_op;
    assign reg_write_o     = w_ctrl.reg_write;
    assign reg_dst_o       = w_ctrl.reg_dst;
    assign mem_to_reg_o    = w_ctrl.mem_to_reg;
    assign retire_o        = w_ctrl.retire;
    assign illegal_o       = w_ctrl.illegal;
    assign state_o         = r_state;
    assign instr_cnt_o     = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Each issued
//               instruction pushes its expected per-cycle control words onto
//               a queue; the run loop pops one entry per cycle, drives the
//               inputs it carries and compares every output. A second
//               instance with a 3-bit counter shares all inputs to observe
//               counter wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [3:0] c_fetch = 4'd0,  c_decode = 4'd1, c_mem_addr = 4'd2,
                           c_mem_rd = 4'd3, c_mem_wb = 4'd4, c_mem_wr = 4'd5,
                           c_exec_r = 4'd6, c_r_wb = 4'd7,   c_branch = 4'd8,
                           c_exec_i = 4'd9, c_i_wb = 4'd10,  c_jump = 4'd11;

    localparam logic [5:0] c_rtype = 6'd0, c_j = 6'd2, c_beq = 6'd4, c_bne = 6'd5,
                           c_addi = 6'd8, c_slti = 6'd10, c_lw = 6'd35, c_sw = 6'd43;

    typedef struct {
        logic        rst;
        logic        ready;
        logic [5:0]  op;
        logic [23:0] exp;
    } cyc_t;

    logic        clk = 1'b0;
    logic        r_rst;
    logic        r_ready;
    logic [5:0]  r_op;

    logic        w_req, w_we, w_iod, w_irw, w_pcw, w_pcwc, w_bne, w_sa, w_rw, w_rd, w_m2r, w_ret, w_ill;
    logic [1:0]  w_pcs, w_sb;
    logic [2:0]  w_aop;
    logic [3:0]  w_state;
    logic [31:0] w_cnt;

    logic        s_req, s_we, s_iod, s_irw, s_pcw, s_pcwc, s_bne, s_sa, s_rw, s_rd, s_m2r, s_ret, s_ill;
    logic [1:0]  s_pcs, s_sb;
    logic [2:0]  s_aop;
    logic [3:0]  s_state;
    logic [2:0]  s_cnt;

    logic [23:0] w_obs, s_obs;

    cyc_t        q[$];
    int unsigned exp_cnt = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_i(r_rst), .opcode_i(r_op), .mem_ready_i(r_ready),
        .mem_req_o(w_req), .mem_we_o(w_we), .i_or_d_o(w_iod), .ir_write_o(w_irw),
        .pc_write_o(w_pcw), .pc_write_cond_o(w_pcwc), .branch_ne_o(w_bne),
        .pc_source_o(w_pcs), .alu_src_a_o(w_sa), .alu_src_b_o(w_sb), .alu_op_o(w_aop),
        .reg_write_o(w_rw), .reg_dst_o(w_rd), .mem_to_reg_o(w_m2r), .state_o(w_state),
        .retire_o(w_ret), .illegal_o(w_ill), .instr_cnt_o(w_cnt)
    );

    multicycle_ctrl #(.CNT_W(3)) dut_w3 (
        .clk_i(clk), .rst_i(r_rst), .opcode_i(r_op), .mem_ready_i(r_ready),
        .mem_req_o(s_req), .mem_we_o(s_we), .i_or_d_o(s_iod), .ir_write_o(s_irw),
        .pc_write_o(s_pcw), .pc_write_cond_o(s_pcwc), .branch_ne_o(s_bne),
        .pc_source_o(s_pcs), .alu_src_a_o(s_sa), .alu_src_b_o(s_sb), .alu_op_o(s_aop),
        .reg_write_o(s_rw), .reg_dst_o(s_rd), .mem_to_reg_o(s_m2r), .state_o(s_state),
        .retire_o(s_ret), .illegal_o(s_ill), .instr_cnt_o(s_cnt)
    );

    assign w_obs = {w_state, w_req, w_we, w_iod, w_irw, w_pcw, w_pcwc, w_bne, w_pcs,
                    w_sa, w_sb, w_aop, w_rw, w_rd, w_m2r, w_ret, w_ill};
    assign s_obs = {s_state, s_req, s_we, s_iod, s_irw, s_pcw, s_pcwc, s_bne, s_pcs,
                    s_sa, s_sb, s_aop, s_rw, s_rd, s_m2r, s_ret, s_ill};

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Reference control word for one cycle, written from the state table
    function automatic logic [23:0] model(input logic [3:0] st, input logic [5:0] op,
                                          input logic rdy, input logic rst);
        logic       req = 0, we = 0, iod = 0, irw = 0, pcw = 0, pcwc = 0, bne = 0;
        logic       sa = 0, rw = 0, rd = 0, m2r = 0, ret = 0, ill = 0;
        logic [1:0] pcs = 0, sb = 0;
        logic [2:0] aop = 0;
        if (rst) begin
            sb = 2'd1;
        end else begin
            case (st)
                c_fetch:    begin req = 1; sb = 2'd1; irw = rdy; pcw = rdy; end
                c_decode:   begin sb = 2'd3;
                                  ill = !(op inside {c_rtype, c_j, c_beq, c_bne,
                                                     c_addi, c_slti, c_lw, c_sw}); end
                c_mem_addr: begin sa = 1; sb = 2'd2; end
                c_mem_rd:   begin req = 1; iod = 1; end
                c_mem_wb:   begin rw = 1; m2r = 1; ret = 1; end
                c_mem_wr:   begin req = 1; we = 1; iod = 1; ret = rdy; end
                c_exec_r:   begin sa = 1; aop = 3'b010; end
                c_r_wb:     begin rw = 1; rd = 1; ret = 1; end
                c_branch:   begin sa = 1; aop = 3'b001; pcwc = 1; pcs = 2'd1;
                                  bne = (op == c_bne); ret = 1; end
                c_exec_i:   begin sa = 1; sb = 2'd2; aop = (op == c_slti) ? 3'b011 : 3'b000; end
                c_i_wb:     begin rw = 1; ret = 1; end
                c_jump:     begin pcw = 1; pcs = 2'd2; ret = 1; end
                default:    ;
            endcase
        end
        return {st, req, we, iod, irw, pcw, pcwc, bne, pcs, sa, sb, aop, rw, rd, m2r, ret, ill};
    endfunction

    task automatic push(input logic rst, input logic rdy, input logic [5:0] op, input logic [3:0] st);
        cyc_t e;
        e.rst   = rst;
        e.ready = rdy;
        e.op    = op;
        e.exp   = model(st, op, rdy, rst);
        q.push_back(e);
    endtask

    // Push the full cycle sequence of one instruction; ready is random
    // wherever the controller must ignore it, opcode is random during FETCH.
    task automatic issue(input logic [5:0] op, input int fetch_wait, input int mem_wait);
        for (int i = 0; i < fetch_wait; i++) push(0, 0, 6'($urandom), c_fetch);
        push(0, 1, 6'($urandom), c_fetch);
        push(0, 1'($urandom), op, c_decode);
        case (op)
            c_lw: begin
                push(0, 1'($urandom), op, c_mem_addr);
                for (int i = 0; i < mem_wait; i++) push(0, 0, op, c_mem_rd);
                push(0, 1, op, c_mem_rd);
                push(0, 1'($urandom), op, c_mem_wb);
            end
            c_sw: begin
                push(0, 1'($urandom), op, c_mem_addr);
                for (int i = 0; i < mem_wait; i++) push(0, 0, op, c_mem_wr);
                push(0, 1, op, c_mem_wr);
            end
            c_rtype: begin
                push(0, 1'($urandom), op, c_exec_r);
                push(0, 1'($urandom), op, c_r_wb);
            end
            c_beq, c_bne: push(0, 1'($urandom), op, c_branch);
            c_addi, c_slti: begin
                push(0, 1'($urandom), op, c_exec_i);
                push(0, 1'($urandom), op, c_i_wb);
            end
            c_j: push(0, 1'($urandom), op, c_jump);
            default: ;
        endcase
    endtask

    // Drain the scoreboard: one entry per clock, sampled mid-cycle
    task automatic run();
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            r_rst   = e.rst;
            r_ready = e.ready;
            r_op    = e.op;
            #1;
            check($sformatf("ctrl st%0d", e.exp[23:20]), 32'(w_obs), 32'(e.exp));
            check("ctrl_w3", 32'(s_obs), 32'(e.exp));
            check("instr_cnt", w_cnt, 32'(exp_cnt));
            check("instr_cnt_w3", 32'(s_cnt), 32'(exp_cnt % 8));
            if (e.rst)        exp_cnt = 0;
            else if (e.exp[1]) exp_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        r_rst   = 1'b1;
        r_ready = 1'b0;
        r_op    = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held: FETCH state, every enable low
        push(1, 1, 6'd0, c_fetch);
        issue(c_rtype, 0, 0);
        issue(c_lw, 0, 2);
        issue(c_bne, 0, 0);
        issue(6'h3F, 0, 0);
        issue(c_beq, 1, 0);
        issue(c_addi, 0, 0);
        issue(c_slti, 0, 1);
        issue(c_sw, 0, 1);
        issue(c_j, 0, 0);
        issue(6'd1, 0, 0);
        run();

        // Reset while a store waits on memory, with ready arriving that cycle
        push(0, 1, 6'($urandom), c_fetch);
        push(0, 0, c_sw, c_decode);
        push(0, 0, c_sw, c_mem_addr);
        push(0, 0, c_sw, c_mem_wr);
        push(0, 0, c_sw, c_mem_wr);
        push(1, 1, c_sw, c_mem_wr);
        // Eight jumps: 3-bit counter walks 0..7 and wraps back to 0
        for (int i = 0; i < 8; i++) issue(c_j, 0, 0);
        push(0, 0, 6'($urandom), c_fetch);
        run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore control FSM that sequences a shared multi-cycle MIPS datapath: one ALU, one unified memory port, PC, IR and the register file.
- Breaks each instruction into FETCH / DECODE / EXEC / MEM / WB steps and drives all enables and mux selects.
- Waits on a memory ready handshake.
- Counts retired instructions.
- Sits beside the datapath top level, replacing the single-cycle decoder.

Parameters:
CNT_W, 32, width of retired-instruction counter
OP_RTYPE, 6'd0, R-type opcode (funct decoded by ALU control)
OP_J, 6'd2, jump
OP_BEQ, 6'd4, branch equal
OP_BNE, 6'd5, branch not equal
OP_ADDI, 6'd8, add immediate
OP_SLTI, 6'd10, set-less-than immediate
OP_LW, 6'd35, load word
OP_SW, 6'd43, store word

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
opcode_i  in  6  IR[31:26], valid from DECODE onward
mem_ready_i  in  1  memory completes current request this cycle
mem_req_o  out  1  memory request, held until mem_ready_i
mem_we_o  out  1  1 = write (SW), 0 = read
i_or_d_o  out  1  memory address: 0 = PC, 1 = ALUOut
ir_write_o  out  1  load IR from memory data
pc_write_o  out  1  unconditional PC load
pc_write_cond_o  out  1  PC load if branch condition holds
branch_ne_o  out  1  condition select: 0 = zero, 1 = ~zero
pc_source_o  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
alu_src_a_o  out  1  0 = PC, 1 = RS data
alu_src_b_o  out  2  0 = RT, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
alu_op_o  out  3  000 add, 001 sub, 010 funct, 011 slt
reg_write_o  out  1  register-file write enable
reg_dst_o  out  1  0 = rt, 1 = rd
mem_to_reg_o  out  1  0 = ALUOut, 1 = MDR
state_o  out  4  current state (debug/verification)
retire_o  out  1  one-cycle pulse when an instruction completes
illegal_o  out  1  one-cycle pulse in DECODE on an unknown opcode
instr_cnt_o  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, EXEC_I=9, I_WB=10, JUMP=11. Codes 12-15 go to FETCH next cycle.
- Reset: rst_i high on an edge gives state=FETCH, instr_cnt_o=0. While rst_i is high, all write enables, mem_req_o, retire_o and illegal_o are forced to 0. Selects take their FETCH values. Reset mid-instruction abandons it with no write.
- All outputs except the counter are combinational from the registered state (plus mem_ready_i and rst_i gating). No Mealy paths from opcode_i except the DECODE next-state.
- FETCH: mem_req=1, i_or_d=0, src_a=0, src_b=1, alu_op=add, pc_source=0. ir_write and pc_write equal mem_ready_i. Stays in FETCH until ready, then goes to DECODE.
- DECODE: src_a=0, src_b=3, alu_op=add (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEM_ADDR
  - RTYPE -> EXEC_R
  - BEQ/BNE -> BRANCH
  - ADDI/SLTI -> EXEC_I
  - J -> JUMP
  - anything else -> FETCH with illegal_o=1 and no retire
- MEM_ADDR: src_a=1, src_b=2, add. Next is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req=1, i_or_d=1. Holds until ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, retire. Next FETCH.
- MEM_WR: mem_req=1, mem_we=1, i_or_d=1. Holds until ready. The ready cycle retires and goes to FETCH.
- EXEC_R: src_a=1, src_b=0, alu_op=funct. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire. Next FETCH.
- BRANCH: src_a=1, src_b=0, sub, pc_write_cond=1, pc_source=1, branch_ne=(opcode==BNE), retire. Next FETCH.
- EXEC_I: src_a=1, src_b=2, alu_op = add for ADDI, slt for SLTI. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retire. Next FETCH.
- JUMP: pc_write=1, pc_source=2, retire. Next FETCH.
- Don't-care outputs are driven 0.
- Counter: instr_cnt_o increments on the edge ending each retire_o cycle. It wraps 2^CNT_W-1 -> 0 with no flag.
- mem_ready_i outside FETCH/MEM_RD/MEM_WR is ignored.
- Latency in cycles with zero-wait memory: R=4, ADDI/SLTI=4, BEQ/BNE=3, J=3, LW=5, SW=4. Each memory wait cycle adds 1.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state localparams
  - opcode constants
  - alu_op codes (also used by ALU_Ctrl)
  - src_b and pc_source encodings
- Natural sub-module: multicycle_ctrl_outdec, a purely combinational state -> control-word decoder. The top keeps the state register, next-state logic and counter.

Test Plan:
- Reset with rst_i=1 for 2 cycles -> state_o=0, instr_cnt_o=0, reg_write_o=pc_write_o=mem_req_o=0; after release mem_req_o=1, i_or_d_o=0.
- R-type (opcode 0), mem_ready_i always 1 -> states 0,1,6,7,0; reg_write_o=1 only in state 7 with reg_dst_o=1; instr_cnt_o=1.
- LW with mem_ready_i low 2 cycles in MEM_RD -> MEM_RD held 3 cycles; total 7 cycles; reg_write_o with mem_to_reg_o=1 in MEM_WB.
- BNE (opcode 5) -> BRANCH shows pc_write_cond_o=1, branch_ne_o=1, pc_source_o=1, alu_op_o=001; 3 cycles.
- Opcode 6'h3F -> illegal_o pulse in DECODE, back to FETCH, instr_cnt_o unchanged, no writes.
- rst_i asserted during MEM_WR while waiting -> next state 0, mem_we_o=0; counter preload to 2^32-1 then one J -> instr_cnt_o=0.
